// File: rtl/audio_in_stereo_reader_pkg.sv
// Shared definitions for the audio-in stereo reader slice.
//  - FSM state encoding of the FIFO pop controller
//  - field positions inside the 8-bit FIFO read_space word
//  - default widths for the reader and its peak meter
//  - helpers that decode a read_space word
package audio_in_stereo_reader_pkg;

  localparam int FULL_BIT             = 7;
  localparam int USED_MSB             = 6;
  localparam int SPACE_WIDTH          = 8;
  localparam int DEF_AUDIO_DATA_WIDTH = 32;
  localparam int DEF_OUT_WIDTH        = 16;
  localparam int DEF_WINDOW_SAMPLES   = 1024;
  localparam int DEF_CNT_WIDTH        = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POP     = 3'd1,
    ST_SETTLE1 = 3'd2,
    ST_SETTLE2 = 3'd3,
    ST_DISCARD = 3'd4
  } reader_state_t;

  // A FIFO holds at least one word when it is full or its used count is non-zero.
  function automatic logic fifo_has_word(input logic [SPACE_WIDTH-1:0] space);
    return space[FULL_BIT] | (space[USED_MSB:0] != 7'd0);
  endfunction

  function automatic logic fifo_is_full(input logic [SPACE_WIDTH-1:0] space);
    return space[FULL_BIT];
  endfunction

endpackage

// File: rtl/audio_peak_meter.sv
// Windowed peak-level meter.
//  Every handshake folds max(|left|,|right|) into a running maximum. After
//  WINDOW_SAMPLES handshakes the maximum is published on peak_level with a
//  one-cycle peak_valid pulse, loud_detect is compared against the threshold
//  sampled at that same edge, and the window restarts.
// Ports:
//  clk, reset        clock, synchronous active-high reset
//  handshake         one accepted stereo pair this cycle
//  left, right       signed samples of the accepted pair
//  level_threshold   unsigned magnitude threshold
//  peak_level        max |sample| of the last completed window
//  peak_valid        one-cycle pulse when peak_level updates
//  loud_detect       peak_level >= threshold, updated with peak_valid
module audio_peak_meter
  import audio_in_stereo_reader_pkg::*;
#(
  parameter int OUT_WIDTH      = DEF_OUT_WIDTH,
  parameter int WINDOW_SAMPLES = DEF_WINDOW_SAMPLES,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 handshake,
  input  logic [OUT_WIDTH-1:0] left,
  input  logic [OUT_WIDTH-1:0] right,
  input  logic [OUT_WIDTH-2:0] level_threshold,
  output logic [OUT_WIDTH-2:0] peak_level,
  output logic                 peak_valid,
  output logic                 loud_detect
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(WINDOW_SAMPLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Magnitude of a two's-complement sample; the most negative code has no
  // positive counterpart and clips to the largest positive magnitude.
  function automatic logic [OUT_WIDTH-2:0] abs_sat(input logic [OUT_WIDTH-1:0] x);
    logic [OUT_WIDTH-1:0] neg_v;
    neg_v = -x;
    if (!x[OUT_WIDTH-1]) begin
      return x[OUT_WIDTH-2:0];
    end else if (neg_v[OUT_WIDTH-1]) begin
      return {(OUT_WIDTH-1){1'b1}};
    end else begin
      return neg_v[OUT_WIDTH-2:0];
    end
  endfunction

  logic [OUT_WIDTH-2:0] acc_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [OUT_WIDTH-2:0] left_mag_s;
  logic [OUT_WIDTH-2:0] right_mag_s;
  logic [OUT_WIDTH-2:0] mag_s;
  logic [OUT_WIDTH-2:0] cand_s;

  assign left_mag_s  = abs_sat(left);
  assign right_mag_s = abs_sat(right);
  assign mag_s       = (left_mag_s > right_mag_s) ? left_mag_s : right_mag_s;
  assign cand_s      = (acc_r > mag_s) ? acc_r : mag_s;

  // Window accumulation and end-of-window publication.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      peak_level  <= '0;
      peak_valid  <= 1'b0;
      loud_detect <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      if (handshake) begin
        if (cnt_r == LAST_CNT) begin
          peak_level  <= cand_s;
          peak_valid  <= 1'b1;
          loud_detect <= (cand_s >= level_threshold);
          acc_r       <= '0;
          cnt_r       <= '0;
        end else begin
          acc_r <= cand_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/audio_in_stereo_reader.sv
// Stereo reader for the audio-in deserializer's left/right show-ahead FIFOs.
//  Pops one word from each FIFO as an aligned pair, truncates each word to its
//  top OUT_WIDTH bits, presents the pair on a valid/ready stream and feeds an
//  accepted pair into a windowed peak meter. When one FIFO is full while the
//  other is empty the channels have slipped, and one word is dropped from the
//  full side to realign them.
// Ports:
//  clk, reset                         clock, synchronous active-high reset
//  left/right_audio_fifo_read_space   [7]=full, [6:0]=used (lags pops)
//  left/right_channel_data            head words (bit AUDIO_DATA_WIDTH = MSB)
//  read_left/right_audio_data_en      one-cycle pop strobes
//  sample_valid/sample_ready          output stream handshake
//  left_sample/right_sample           signed truncated samples
//  level_threshold                    loudness threshold for the meter
//  peak_level/peak_valid/loud_detect  meter outputs
//  misalign_count                     realignment discards, saturating
module audio_in_stereo_reader
  import audio_in_stereo_reader_pkg::*;
#(
  parameter int AUDIO_DATA_WIDTH = DEF_AUDIO_DATA_WIDTH,
  parameter int OUT_WIDTH        = DEF_OUT_WIDTH,
  parameter int WINDOW_SAMPLES   = DEF_WINDOW_SAMPLES,
  parameter int CNT_WIDTH        = DEF_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SPACE_WIDTH-1:0]      left_audio_fifo_read_space,
  input  logic [SPACE_WIDTH-1:0]      right_audio_fifo_read_space,
  input  logic [AUDIO_DATA_WIDTH:1]   left_channel_data,
  input  logic [AUDIO_DATA_WIDTH:1]   right_channel_data,
  output logic                        read_left_audio_data_en,
  output logic                        read_right_audio_data_en,
  output logic                        sample_valid,
  input  logic                        sample_ready,
  output logic signed [OUT_WIDTH-1:0] left_sample,
  output logic signed [OUT_WIDTH-1:0] right_sample,
  input  logic [OUT_WIDTH-2:0]        level_threshold,
  output logic [OUT_WIDTH-2:0]        peak_level,
  output logic                        peak_valid,
  output logic                        loud_detect,
  output logic [7:0]                  misalign_count
);

  reader_state_t state_r;

  logic l_avail_s;
  logic r_avail_s;
  logic mis_left_s;
  logic mis_right_s;
  logic handshake_s;
  logic unused_s;

  assign l_avail_s   = fifo_has_word(left_audio_fifo_read_space);
  assign r_avail_s   = fifo_has_word(right_audio_fifo_read_space);
  // Slip: one side full while the other is completely empty.
  assign mis_left_s  = fifo_is_full(left_audio_fifo_read_space) & ~r_avail_s;
  assign mis_right_s = fifo_is_full(right_audio_fifo_read_space) & ~l_avail_s;
  assign handshake_s = sample_valid & sample_ready;

  // Truncated-away low bits of the FIFO words are intentionally dropped.
  assign unused_s = ^{left_channel_data[AUDIO_DATA_WIDTH-OUT_WIDTH:1],
                      right_channel_data[AUDIO_DATA_WIDTH-OUT_WIDTH:1]};

  // Pop FSM and registered output stage. Strobes are set on entry to POP or
  // DISCARD so they are high for exactly that one state; the two SETTLE
  // states wait out the read_space lag before the next decision. Pops are
  // blocked while a pair is still pending so a stalled consumer never loses
  // data here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r                  <= ST_IDLE;
      read_left_audio_data_en  <= 1'b0;
      read_right_audio_data_en <= 1'b0;
      sample_valid             <= 1'b0;
      left_sample              <= '0;
      right_sample             <= '0;
      misalign_count           <= 8'd0;
    end else begin
      read_left_audio_data_en  <= 1'b0;
      read_right_audio_data_en <= 1'b0;
      if (handshake_s) begin
        sample_valid <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (l_avail_s && r_avail_s && !sample_valid) begin
            state_r                  <= ST_POP;
            left_sample              <= left_channel_data[AUDIO_DATA_WIDTH -: OUT_WIDTH];
            right_sample             <= right_channel_data[AUDIO_DATA_WIDTH -: OUT_WIDTH];
            sample_valid             <= 1'b1;
            read_left_audio_data_en  <= 1'b1;
            read_right_audio_data_en <= 1'b1;
          end else if ((mis_left_s || mis_right_s) && !sample_valid) begin
            state_r                  <= ST_DISCARD;
            read_left_audio_data_en  <= mis_left_s;
            read_right_audio_data_en <= mis_right_s;
            if (misalign_count != 8'hFF) begin
              misalign_count <= misalign_count + 8'd1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_POP:     state_r <= ST_SETTLE1;
        ST_DISCARD: state_r <= ST_SETTLE1;
        ST_SETTLE1: state_r <= ST_SETTLE2;
        ST_SETTLE2: state_r <= ST_IDLE;
        default:    state_r <= ST_IDLE;
      endcase
    end
  end

  audio_peak_meter #(
    .OUT_WIDTH      (OUT_WIDTH),
    .WINDOW_SAMPLES (WINDOW_SAMPLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_peak_meter (
    .clk             (clk),
    .reset           (reset),
    .handshake       (handshake_s),
    .left            (left_sample),
    .right           (right_sample),
    .level_threshold (level_threshold),
    .peak_level      (peak_level),
    .peak_valid      (peak_valid),
    .loud_detect     (loud_detect)
  );

endmodule

// File: tb/tb_audio_in_stereo_reader.sv
// Directed bench for audio_in_stereo_reader with a behavioural model of the
// two show-ahead FIFOs (read_space registered twice after a pop).
module tb_audio_in_stereo_reader;
  import audio_in_stereo_reader_pkg::*;

  localparam int AW = 32;
  localparam int OW = 16;
  localparam int WS = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    left_audio_fifo_read_space = 8'h00;
  logic [7:0]    right_audio_fifo_read_space = 8'h00;
  logic [AW:1]   left_channel_data = '0;
  logic [AW:1]   right_channel_data = '0;
  logic          read_left_audio_data_en;
  logic          read_right_audio_data_en;
  logic          sample_valid;
  logic          sample_ready = 1'b0;
  logic [OW-1:0] left_sample;
  logic [OW-1:0] right_sample;
  logic [OW-2:0] level_threshold = '0;
  logic [OW-2:0] peak_level;
  logic          peak_valid;
  logic          loud_detect;
  logic [7:0]    misalign_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  audio_in_stereo_reader #(
    .AUDIO_DATA_WIDTH (AW),
    .OUT_WIDTH        (OW),
    .WINDOW_SAMPLES   (WS),
    .CNT_WIDTH        (CW)
  ) dut (
    .clk                         (clk),
    .reset                       (reset),
    .left_audio_fifo_read_space  (left_audio_fifo_read_space),
    .right_audio_fifo_read_space (right_audio_fifo_read_space),
    .left_channel_data           (left_channel_data),
    .right_channel_data          (right_channel_data),
    .read_left_audio_data_en     (read_left_audio_data_en),
    .read_right_audio_data_en    (read_right_audio_data_en),
    .sample_valid                (sample_valid),
    .sample_ready                (sample_ready),
    .left_sample                 (left_sample),
    .right_sample                (right_sample),
    .level_threshold             (level_threshold),
    .peak_level                  (peak_level),
    .peak_valid                  (peak_valid),
    .loud_detect                 (loud_detect),
    .misalign_count              (misalign_count)
  );

  // FIFO model
  logic [31:0] lq[$];
  logic [31:0] rq[$];
  logic [7:0]  l_stage = 8'h00;
  logic [7:0]  r_stage = 8'h00;
  logic        ovr_en = 1'b0;
  logic [7:0]  ovr_l = 8'h00;
  logic [7:0]  ovr_r = 8'h00;

  function automatic logic [7:0] enc(input int n);
    if (n >= 128) return 8'h80;
    else return {1'b0, 7'(n)};
  endfunction

  always @(posedge clk) begin
    if (read_left_audio_data_en && lq.size() > 0) lq.delete(0);
    if (read_right_audio_data_en && rq.size() > 0) rq.delete(0);
    l_stage <= enc(lq.size());
    r_stage <= enc(rq.size());
    if (ovr_en) begin
      left_audio_fifo_read_space  <= ovr_l;
      right_audio_fifo_read_space <= ovr_r;
    end else begin
      left_audio_fifo_read_space  <= l_stage;
      right_audio_fifo_read_space <= r_stage;
    end
    left_channel_data  <= (lq.size() > 0) ? lq[0] : 32'h0;
    right_channel_data <= (rq.size() > 0) ? rq[0] : 32'h0;
  end

  // Monitor (mid-cycle sampling)
  int cyc = 0;
  int lstb = 0;
  int rstb = 0;
  int gap_viol = 0;
  int last_pop = -100;
  int pv_cnt = 0;
  logic [OW-2:0] pv_level = '0;
  logic          pv_loud = 1'b0;
  logic [OW-1:0] got_l[$];
  logic [OW-1:0] got_r[$];

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      last_pop = -100;
    end else begin
      if (read_left_audio_data_en || read_right_audio_data_en) begin
        if (cyc - last_pop < 4) gap_viol++;
        last_pop = cyc;
      end
      if (sample_valid && sample_ready) begin
        got_l.push_back(left_sample);
        got_r.push_back(right_sample);
      end
    end
    if (read_left_audio_data_en) lstb++;
    if (read_right_audio_data_en) rstb++;
    if (peak_valid) begin
      pv_cnt++;
      pv_level = peak_level;
      pv_loud  = loud_detect;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if ({read_left_audio_data_en, read_right_audio_data_en, sample_valid, left_sample,
         right_sample, peak_level, peak_valid, loud_detect, misalign_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b l=%h r=%h peak=%h mis=%0d, expected all 0",
               sample_valid, left_sample, right_sample, peak_level, misalign_count);
    end
    checks++;
    if (dut.state_r !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dut.state_r, ST_IDLE);
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_stream();
    int sl, sr, sp, g0;
    sl = lstb; sr = rstb; sp = got_l.size(); g0 = gap_viol;
    sample_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lq.push_back(32'h7FFF_0000 + i);
      rq.push_back(32'h8000_0000 + i);
    end
    tick(40);
    checks++;
    if (lstb - sl != 3 || rstb - sr != 3) begin
      errors++;
      $display("FAIL stream_strobes: got L=%0d R=%0d expected 3/3", lstb - sl, rstb - sr);
    end
    checks++;
    if (got_l.size() - sp != 3) begin
      errors++;
      $display("FAIL stream_pairs: got %0d expected 3", got_l.size() - sp);
    end
    for (int i = 0; i < 3; i++) begin
      if (sp + i < got_l.size()) begin
        checks++;
        if (got_l[sp+i] !== 16'h7FFF || got_r[sp+i] !== 16'h8000) begin
          errors++;
          $display("FAIL stream_data%0d: got %h/%h expected 7fff/8000", i, got_l[sp+i], got_r[sp+i]);
        end
      end
    end
    checks++;
    if (gap_viol != g0) begin
      errors++;
      $display("FAIL stream_spacing: got %0d close pops expected 0", gap_viol - g0);
    end
  endtask

  task automatic test_one_sided();
    int sl, sr, sp;
    sl = lstb; sr = rstb; sp = got_l.size();
    for (int i = 0; i < 5; i++) lq.push_back({16'h2000 + 16'(i), 16'h0000});
    tick(20);
    checks++;
    if (lstb != sl || rstb != sr || sample_valid !== 1'b0 || got_l.size() != sp) begin
      errors++;
      $display("FAIL one_sided_idle: got strobes %0d/%0d valid=%0b expected 0/0 valid=0",
               lstb - sl, rstb - sr, sample_valid);
    end
    rq.push_back({16'hA000, 16'h0000});
    tick(20);
    checks++;
    if (lstb - sl != 1 || rstb - sr != 1 || got_l.size() - sp != 1) begin
      errors++;
      $display("FAIL one_sided_pair: got strobes %0d/%0d pairs %0d expected 1/1/1",
               lstb - sl, rstb - sr, got_l.size() - sp);
    end else begin
      checks++;
      if (got_l[sp] !== 16'h2000 || got_r[sp] !== 16'hA000) begin
        errors++;
        $display("FAIL one_sided_data: got %h/%h expected 2000/a000", got_l[sp], got_r[sp]);
      end
    end
  endtask

  task automatic test_stall();
    int sl, sp;
    sample_ready = 1'b0;
    sp = got_l.size();
    for (int i = 1; i < 5; i++) rq.push_back({16'hA000 + 16'(i), 16'h0000});
    tick(10);
    checks++;
    if (sample_valid !== 1'b1 || left_sample !== 16'h2001 || right_sample !== 16'hA001) begin
      errors++;
      $display("FAIL stall_hold: got valid=%0b %h/%h expected 1 2001/a001",
               sample_valid, left_sample, right_sample);
    end
    sl = lstb;
    tick(50);
    checks++;
    if (sample_valid !== 1'b1 || left_sample !== 16'h2001 || right_sample !== 16'hA001 || lstb != sl) begin
      errors++;
      $display("FAIL stall_stable: got valid=%0b %h/%h pops %0d expected 1 2001/a001 0",
               sample_valid, left_sample, right_sample, lstb - sl);
    end
    sample_ready = 1'b1;
    tick(30);
    checks++;
    if (got_l.size() - sp != 4) begin
      errors++;
      $display("FAIL stall_resume_count: got %0d expected 4", got_l.size() - sp);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_l[sp+i] !== 16'h2001 + 16'(i) || got_r[sp+i] !== 16'hA001 + 16'(i)) begin
          errors++;
          $display("FAIL stall_resume_data%0d: got %h/%h expected %h/%h", i, got_l[sp+i],
                   got_r[sp+i], 16'h2001 + 16'(i), 16'hA001 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_misalign();
    int sl, sr, sp;
    bit found;
    sl = lstb; sr = rstb; sp = got_l.size();
    ovr_l = 8'h80; ovr_r = 8'h00; ovr_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick(1);
      if (read_left_audio_data_en) found = 1'b1;
    end
    ovr_en = 1'b0;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL misalign_timeout: no left strobe within 30 cycles");
    end
    tick(10);
    checks++;
    if (misalign_count !== 8'd1 || lstb - sl != 1 || rstb != sr || got_l.size() != sp || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_single: got count=%0d L=%0d R=%0d pairs=%0d expected 1/1/0/0",
               misalign_count, lstb - sl, rstb - sr, got_l.size() - sp);
    end
    ovr_en = 1'b1;
    tick(1300);
    ovr_en = 1'b0;
    tick(10);
    checks++;
    if (misalign_count !== 8'd255) begin
      errors++;
      $display("FAIL misalign_saturate: got %0d expected 255", misalign_count);
    end
    checks++;
    if (lstb - sl < 256 || rstb != sr || got_l.size() != sp) begin
      errors++;
      $display("FAIL misalign_side: got L=%0d R=%0d pairs=%0d expected >=256/0/0",
               lstb - sl, rstb - sr, got_l.size() - sp);
    end
  endtask

  task automatic test_both_full();
    int sl, sr, sp;
    bit found;
    sl = lstb; sr = rstb; sp = got_l.size();
    ovr_l = 8'h80; ovr_r = 8'h80; ovr_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick(1);
      if (read_left_audio_data_en) found = 1'b1;
    end
    ovr_en = 1'b0;
    checks++;
    if (!found || read_right_audio_data_en !== 1'b1) begin
      errors++;
      $display("FAIL both_full_strobe: got found=%0b right=%0b expected 1/1", found, read_right_audio_data_en);
    end
    tick(10);
    checks++;
    if (misalign_count !== 8'd255 || got_l.size() - sp != 1 || lstb - sl != 1 || rstb - sr != 1) begin
      errors++;
      $display("FAIL both_full_pop: got mis=%0d pairs=%0d L=%0d R=%0d expected 255/1/1/1",
               misalign_count, got_l.size() - sp, lstb - sl, rstb - sr);
    end
  endtask

  task automatic test_meter();
    int p0, sp;
    logic [15:0] wl[4];
    logic [15:0] wr[4];
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    sample_ready = 1'b1;
    level_threshold = 15'd1000;
    p0 = pv_cnt; sp = got_l.size();
    wl = '{16'd100, 16'd900, 16'h8000, 16'd5};
    wr = '{16'hFFCE, 16'd0, 16'd0, 16'd0};
    for (int i = 0; i < 3; i++) begin
      lq.push_back({wl[i], 16'h0000});
      rq.push_back({wr[i], 16'h0000});
    end
    tick(20);
    checks++;
    if (pv_cnt != p0 || got_l.size() - sp != 3) begin
      errors++;
      $display("FAIL meter_early: got pulses=%0d pairs=%0d expected 0/3", pv_cnt - p0, got_l.size() - sp);
    end
    lq.push_back({wl[3], 16'h0000});
    rq.push_back({wr[3], 16'h0000});
    tick(12);
    checks++;
    if (pv_cnt - p0 != 1 || pv_level !== 15'd32767 || pv_loud !== 1'b1) begin
      errors++;
      $display("FAIL meter_window1: got pulses=%0d peak=%0d loud=%0b expected 1/32767/1",
               pv_cnt - p0, pv_level, pv_loud);
    end
    checks++;
    if (peak_valid !== 1'b0 || peak_level !== 15'd32767 || loud_detect !== 1'b1) begin
      errors++;
      $display("FAIL meter_hold1: got pv=%0b peak=%0d loud=%0b expected 0/32767/1",
               peak_valid, peak_level, loud_detect);
    end
    // threshold changes mid-window must not touch loud_detect until window end
    level_threshold = 15'd2000;
    wl = '{16'd10, 16'hFC19, 16'd20, 16'd3};
    wr = '{16'd7, 16'd0, 16'hFFFB, 16'd998};
    for (int i = 0; i < 2; i++) begin
      lq.push_back({wl[i], 16'h0000});
      rq.push_back({wr[i], 16'h0000});
    end
    tick(15);
    checks++;
    if (loud_detect !== 1'b1 || peak_level !== 15'd32767 || pv_cnt - p0 != 1) begin
      errors++;
      $display("FAIL meter_midwindow: got loud=%0b peak=%0d pulses=%0d expected 1/32767/1",
               loud_detect, peak_level, pv_cnt - p0);
    end
    level_threshold = 15'd999;
    for (int i = 2; i < 4; i++) begin
      lq.push_back({wl[i], 16'h0000});
      rq.push_back({wr[i], 16'h0000});
    end
    tick(15);
    checks++;
    if (pv_cnt - p0 != 2 || pv_level !== 15'd999 || pv_loud !== 1'b1) begin
      errors++;
      $display("FAIL meter_window2: got pulses=%0d peak=%0d loud=%0b expected 2/999/1",
               pv_cnt - p0, pv_level, pv_loud);
    end
    level_threshold = 15'd1000;
    for (int i = 0; i < 4; i++) begin
      lq.push_back({16'd999, 16'h0000});
      rq.push_back({16'hFC1A, 16'h0000});
    end
    tick(30);
    checks++;
    if (pv_cnt - p0 != 3 || peak_level !== 15'd999 || loud_detect !== 1'b0) begin
      errors++;
      $display("FAIL meter_window3: got pulses=%0d peak=%0d loud=%0b expected 3/999/0",
               pv_cnt - p0, peak_level, loud_detect);
    end
  endtask

  task automatic test_reset_mid_pop();
    bit found;
    sample_ready = 1'b0;
    lq.push_back({16'h1234, 16'h0000});
    rq.push_back({16'h5678, 16'h0000});
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick(1);
      if (read_left_audio_data_en && read_right_audio_data_en) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midpop_timeout: no pop within 30 cycles");
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if ({read_left_audio_data_en, read_right_audio_data_en, sample_valid, left_sample,
         right_sample, peak_level, peak_valid, loud_detect, misalign_count} !== '0) begin
      errors++;
      $display("FAIL midpop_outputs: got en=%0b%0b valid=%0b l=%h r=%h peak=%0d expected all 0",
               read_left_audio_data_en, read_right_audio_data_en, sample_valid,
               left_sample, right_sample, peak_level);
    end
    checks++;
    if (dut.state_r !== ST_IDLE) begin
      errors++;
      $display("FAIL midpop_state: got %0d expected %0d", dut.state_r, ST_IDLE);
    end
    tick(3);
    reset = 1'b0;
    tick(10);
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL midpop_lost: got valid=%0b expected 0", sample_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_one_sided();
    test_stall();
    test_misalign();
    test_both_full();
    test_meter();
    test_reset_mid_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
